l2_dir_ctrl: RTL and testbench

L2_DIR_CTRL -- requirements
Module: l2_dir_ctrl

---
 rtl/l2_dir_ctrl.sv | 252 +++++++++++++++++++++++++
 tb/tb_l2_dir_ctrl.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/l2_dir_ctrl.sv
// l2_dir_ctrl: L2 directory controller, I/S/O directory with 4-deep request FIFO; define L2_DIR_STATS_EN for req_cnt/inv_cnt outputs
module l2_dir_ctrl #(
  parameter int MSG_WIDTH  = 4,
  parameter int DATA_WIDTH = 64,
  parameter int TAG_WIDTH  = 5,
  parameter int OWNER_BITS = 2,
  parameter int MESI_WIDTH = 2,
  parameter int DIR_WIDTH  = 4,
  parameter int TAG_ARRAY  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [MSG_WIDTH-1:0]  msg1_type,
  input  logic [DATA_WIDTH-1:0] msg1_data,
  input  logic [TAG_WIDTH-1:0]  msg1_tag,
  input  logic [OWNER_BITS-1:0] msg1_source,
  input  logic [MSG_WIDTH-1:0]  msg3_type,
  input  logic [DATA_WIDTH-1:0] msg3_data,
  input  logic [TAG_WIDTH-1:0]  msg3_tag,
  input  logic [OWNER_BITS-1:0] msg3_source,
  output logic [MSG_WIDTH-1:0]  msg2_type,
  output logic [DATA_WIDTH-1:0] msg2_data,
  output logic [TAG_WIDTH-1:0]  msg2_tag,
  output logic [MESI_WIDTH-1:0] mesi_send,
  output logic [OWNER_BITS-1:0] cache_owner,
  output logic [DIR_WIDTH-1:0]  share_list,
  output logic                  busy,
  output logic                  req_ovf
`ifdef L2_DIR_STATS_EN
  , output logic [15:0]         req_cnt
  , output logic [15:0]         inv_cnt
`endif
);
  localparam logic [MSG_WIDTH-1:0] MSG_EMPTY         = 4'd0;
  localparam logic [MSG_WIDTH-1:0] MSG_LOAD_REQ      = 4'd1;
  localparam logic [MSG_WIDTH-1:0] MSG_STORE_REQ     = 4'd2;
  localparam logic [MSG_WIDTH-1:0] MSG_WB_REQ        = 4'd3;
  localparam logic [MSG_WIDTH-1:0] MSG_LOAD_MEM      = 4'd4;
  localparam logic [MSG_WIDTH-1:0] MSG_STORE_MEM     = 4'd5;
  localparam logic [MSG_WIDTH-1:0] MSG_INV_FWD       = 4'd6;
  localparam logic [MSG_WIDTH-1:0] MSG_DATA_ACK      = 4'd7;
  localparam logic [MSG_WIDTH-1:0] MSG_WB_ACK        = 4'd8;
  localparam logic [MSG_WIDTH-1:0] MSG_LOAD_MEM_ACK  = 4'd9;
  localparam logic [MSG_WIDTH-1:0] MSG_STORE_MEM_ACK = 4'd10;
  localparam logic [MSG_WIDTH-1:0] MSG_INV_FWDACK    = 4'd11;
  localparam logic [MESI_WIDTH-1:0] MESI_I = 2'd0;
  localparam logic [MESI_WIDTH-1:0] MESI_S = 2'd1;
  localparam logic [MESI_WIDTH-1:0] MESI_E = 2'd2;
  localparam logic [MESI_WIDTH-1:0] MESI_M = 2'd3;

  typedef enum logic [2:0] {IDLE, MEM_RD, INV, MEM_WR, RESP} state_t;
  typedef enum logic [1:0] {D_I, D_S, D_O} dst_t;
  typedef struct packed {
    logic [MSG_WIDTH-1:0]  typ;
    logic [TAG_WIDTH-1:0]  tag;
    logic [DATA_WIDTH-1:0] data;
    logic [OWNER_BITS-1:0] src;
  } req_t;

  state_t state, nstate;
  req_t fifo_q [4];
  req_t head, cur;
  logic [1:0] wr_ptr, rd_ptr;
  logic [2:0] cnt;
  logic push, pop, push_ok;
  dst_t dir_st [TAG_ARRAY];
  logic [DIR_WIDTH-1:0] dir_sh [TAG_ARRAY];
  logic [OWNER_BITS-1:0] dir_own [TAG_ARRAY];
  dst_t h_st, c_st, w_st;
  logic [DIR_WIDTH-1:0] h_oh, c_oh, own_oh, inv_mask, pend, n_pend, w_sh, c_sh;
  logic [OWNER_BITS-1:0] h_own, c_own, w_own;
  logic [DATA_WIDTH-1:0] cap_data, n_cap;
  logic ack_seen, n_seen, ld_cur, dir_we, mem_hit, inv_hit, ld_s;
  logic [MSG_WIDTH-1:0] n_type;
  logic [DATA_WIDTH-1:0] n_data;
  logic [TAG_WIDTH-1:0] n_tag;
  logic [MESI_WIDTH-1:0] n_mesi;
  logic [OWNER_BITS-1:0] n_owner;
  logic [DIR_WIDTH-1:0] n_share;

  assign push = msg1_type != MSG_EMPTY;
  assign pop = state == IDLE && cnt != 3'd0;
  assign push_ok = push && (cnt != 3'd4 || pop);
  assign head = fifo_q[rd_ptr];
  assign busy = state != IDLE;
  assign h_st = dir_st[head.tag];
  assign h_own = dir_own[head.tag];
  assign h_oh = DIR_WIDTH'(1) << head.src;
  assign own_oh = DIR_WIDTH'(1) << h_own;
  assign inv_mask = dir_sh[head.tag] & ~h_oh;
  assign c_st = dir_st[cur.tag];
  assign c_sh = dir_sh[cur.tag];
  assign c_own = dir_own[cur.tag];
  assign c_oh = DIR_WIDTH'(1) << cur.src;
  assign ld_s = cur.typ == MSG_LOAD_REQ && c_st == D_S;
  assign mem_hit = msg3_type == (state == MEM_RD ? MSG_LOAD_MEM_ACK : MSG_STORE_MEM_ACK) && msg3_tag == cur.tag;
  assign inv_hit = msg3_type == MSG_INV_FWDACK && msg3_tag == cur.tag && pend[msg3_source];

  // request FIFO pointers, occupancy and sticky overflow flag
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt <= '0;
      req_ovf <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 2'd1;
      if (pop) rd_ptr <= rd_ptr + 2'd1;
      cnt <= cnt + 3'(push_ok) - 3'(pop);
      if (push && !push_ok) req_ovf <= 1'b1;
    end

  // FIFO storage; a full-FIFO write lands in the slot being popped that same edge
  always_ff @(posedge clk)
    if (push_ok) fifo_q[wr_ptr] <= {msg1_type, msg1_tag, msg1_data, msg1_source};

  // directory entries, updated once when a transaction completes
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      for (int i = 0; i < TAG_ARRAY; i++) begin
        dir_st[i] <= D_I;
        dir_sh[i] <= '0;
        dir_own[i] <= '0;
      end
    end else if (dir_we) begin
      dir_st[cur.tag] <= w_st;
      dir_sh[cur.tag] <= w_sh;
      dir_own[cur.tag] <= w_own;
    end

  // next state, next outgoing message and directory update; messages only issue when msg2 is idle
  always_comb begin
    nstate = state;
    n_type = MSG_EMPTY;
    n_data = '0;
    n_tag = cur.tag;
    n_mesi = MESI_I;
    n_owner = cur.src;
    n_share = '0;
    n_pend = pend;
    n_cap = cap_data;
    n_seen = ack_seen;
    ld_cur = 1'b0;
    dir_we = 1'b0;
    w_st = D_I;
    w_sh = '0;
    w_own = '0;
    case (state)
      IDLE: if (pop) begin
        ld_cur = 1'b1;
        n_seen = 1'b0;
        n_tag = head.tag;
        n_owner = head.src;
        if (head.typ == MSG_WB_REQ) begin
          n_type = MSG_STORE_MEM;
          n_data = head.data;
          nstate = MEM_WR;
        end else if (head.typ == MSG_LOAD_REQ || head.typ == MSG_STORE_REQ) begin
          if (h_st == D_O || (head.typ == MSG_STORE_REQ && h_st == D_S && inv_mask != '0)) begin
            n_type = MSG_INV_FWD;
            n_share = h_st == D_O ? own_oh : inv_mask;
            n_pend = n_share;
            n_owner = h_st == D_O ? h_own : head.src;
            nstate = INV;
          end else begin
            n_type = MSG_LOAD_MEM;
            nstate = MEM_RD;
          end
        end
      end
      INV: begin
        if (inv_hit) begin
          n_pend = pend & ~(DIR_WIDTH'(1) << msg3_source);
          n_cap = msg3_data;
        end
        if (pend == '0) begin
          n_seen = 1'b0;
          n_type = c_st == D_O ? MSG_STORE_MEM : MSG_LOAD_MEM;
          n_data = c_st == D_O ? cap_data : '0;
          nstate = c_st == D_O ? MEM_WR : MEM_RD;
        end
      end
      MEM_RD: begin
        if (mem_hit) n_cap = msg3_data;
        if ((mem_hit || ack_seen) && msg2_type == MSG_EMPTY) begin
          n_type = MSG_DATA_ACK;
          n_data = mem_hit ? msg3_data : cap_data;
          n_mesi = cur.typ == MSG_STORE_REQ ? MESI_M : ld_s ? MESI_S : MESI_E;
          dir_we = 1'b1;
          w_st = ld_s ? D_S : D_O;
          w_sh = ld_s ? c_sh | c_oh : '0;
          w_own = ld_s ? c_own : cur.src;
          nstate = RESP;
        end else if (mem_hit) n_seen = 1'b1;
      end
      MEM_WR: begin
        if ((mem_hit || ack_seen) && msg2_type == MSG_EMPTY) begin
          n_type = cur.typ == MSG_WB_REQ ? MSG_WB_ACK : MSG_DATA_ACK;
          n_data = cur.typ == MSG_WB_REQ ? cur.data : cap_data;
          n_mesi = cur.typ == MSG_STORE_REQ ? MESI_M : cur.typ == MSG_LOAD_REQ ? MESI_S : MESI_I;
          dir_we = 1'b1;
          w_st = cur.typ == MSG_STORE_REQ ? D_O : cur.typ == MSG_LOAD_REQ ? D_S : D_I;
          w_sh = cur.typ == MSG_LOAD_REQ ? c_oh : '0;
          w_own = cur.typ == MSG_STORE_REQ ? cur.src : '0;
          nstate = RESP;
        end else if (mem_hit) n_seen = 1'b1;
      end
      RESP: nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  // FSM state, transaction context and registered msg2 outputs
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      cur <= '0;
      pend <= '0;
      cap_data <= '0;
      ack_seen <= 1'b0;
      msg2_type <= MSG_EMPTY;
      msg2_data <= '0;
      msg2_tag <= '0;
      mesi_send <= '0;
      cache_owner <= '0;
      share_list <= '0;
    end else begin
      state <= nstate;
      if (ld_cur) cur <= head;
      pend <= n_pend;
      cap_data <= n_cap;
      ack_seen <= n_seen;
      msg2_type <= n_type;
      msg2_data <= n_data;
      msg2_tag <= n_tag;
      mesi_send <= n_mesi;
      cache_owner <= n_owner;
      share_list <= n_share;
    end

`ifdef L2_DIR_STATS_EN
  // saturating counts of popped requests and issued INV_FWD messages
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      req_cnt <= '0;
      inv_cnt <= '0;
    end else begin
      if (pop && req_cnt != 16'hffff) req_cnt <= req_cnt + 16'd1;
      if (n_type == MSG_INV_FWD && inv_cnt != 16'hffff) inv_cnt <= inv_cnt + 16'd1;
    end
`endif
endmodule

// File: tb/tb_l2_dir_ctrl.sv
// tb_l2_dir_ctrl: directed self-checking bench for l2_dir_ctrl
module tb_l2_dir_ctrl;
  localparam logic [3:0] EMPTY = 4'd0, LOAD_REQ = 4'd1, STORE_REQ = 4'd2, WB_REQ = 4'd3;
  localparam logic [3:0] LOAD_MEM = 4'd4, STORE_MEM = 4'd5, INV_FWD = 4'd6, DATA_ACK = 4'd7;
  localparam logic [3:0] WB_ACK = 4'd8, LOAD_MEM_ACK = 4'd9, STORE_MEM_ACK = 4'd10, INV_FWDACK = 4'd11;
  localparam logic [1:0] ME_S = 2'd1, ME_E = 2'd2, ME_M = 2'd3;

  logic clk = 1'b0;
  logic rst;
  logic [3:0] msg1_type, msg3_type, msg2_type;
  logic [63:0] msg1_data, msg3_data, msg2_data;
  logic [4:0] msg1_tag, msg3_tag, msg2_tag;
  logic [1:0] msg1_source, msg3_source, mesi_send, cache_owner;
  logic [3:0] share_list;
  logic busy, req_ovf;
`ifdef L2_DIR_STATS_EN
  logic [15:0] req_cnt, inv_cnt;
`endif
  int errors = 0;
  int checks = 0;

  l2_dir_ctrl dut (
    .clk(clk), .rst(rst),
    .msg1_type(msg1_type), .msg1_data(msg1_data), .msg1_tag(msg1_tag), .msg1_source(msg1_source),
    .msg3_type(msg3_type), .msg3_data(msg3_data), .msg3_tag(msg3_tag), .msg3_source(msg3_source),
    .msg2_type(msg2_type), .msg2_data(msg2_data), .msg2_tag(msg2_tag), .mesi_send(mesi_send),
    .cache_owner(cache_owner), .share_list(share_list), .busy(busy), .req_ovf(req_ovf)
`ifdef L2_DIR_STATS_EN
    , .req_cnt(req_cnt), .inv_cnt(inv_cnt)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic send1(input logic [3:0] t, input logic [4:0] tag, input logic [63:0] d, input logic [1:0] s);
    msg1_type = t; msg1_tag = tag; msg1_data = d; msg1_source = s;
    tick;
    msg1_type = EMPTY;
  endtask

  task automatic send3(input logic [3:0] t, input logic [4:0] tag, input logic [63:0] d, input logic [1:0] s);
    msg3_type = t; msg3_tag = tag; msg3_data = d; msg3_source = s;
    tick;
    msg3_type = EMPTY;
  endtask

  task automatic wait_type(input logic [3:0] t, input string name);
    int n = 0;
    while (msg2_type !== t && n < 40) begin
      tick;
      n++;
    end
    chk(name, msg2_type, t);
  endtask

  task automatic serve_load(input logic [4:0] tag, input logic [1:0] src, input logic [63:0] d, input logic [1:0] mesi);
    wait_type(LOAD_MEM, "ld_mem");
    chk("ld_mem_tag", msg2_tag, tag);
    tick;
    send3(LOAD_MEM_ACK, tag, d, 2'd0);
    chk("dack_type", msg2_type, DATA_ACK);
    chk("dack_tag", msg2_tag, tag);
    chk("dack_owner", cache_owner, src);
    chk("dack_mesi", mesi_send, mesi);
    chk("dack_data", msg2_data, d);
  endtask

  initial begin
    rst = 1'b1;
    msg1_type = EMPTY; msg1_tag = '0; msg1_data = '0; msg1_source = '0;
    msg3_type = EMPTY; msg3_tag = '0; msg3_data = '0; msg3_source = '0;
    tick;
    tick;
    chk("rst_busy", busy, 0);
    chk("rst_type", msg2_type, EMPTY);
    chk("rst_ovf", req_ovf, 0);
    chk("rst_share", share_list, 0);
    chk("rst_owner", cache_owner, 0);
    chk("rst_mesi", mesi_send, 0);
    chk("rst_data", msg2_data, 0);
    rst = 1'b0;
    tick;
    // load tag 5 from core 2, state I: exact latency
    send1(LOAD_REQ, 5'd5, 64'd0, 2'd2);
    chk("l5_c1_type", msg2_type, EMPTY);
    chk("l5_c1_busy", busy, 0);
    tick;
    chk("l5_c2_type", msg2_type, LOAD_MEM);
    chk("l5_c2_tag", msg2_tag, 5);
    chk("l5_c2_busy", busy, 1);
    tick;
    chk("l5_c3_type", msg2_type, EMPTY);
    send3(LOAD_MEM_ACK, 5'd5, 64'd0, 2'd0);
    chk("l5_c4_type", msg2_type, DATA_ACK);
    chk("l5_c4_owner", cache_owner, 2);
    chk("l5_c4_mesi", mesi_send, ME_E);
    chk("l5_c4_data", msg2_data, 0);
    tick;
    chk("l5_c5_type", msg2_type, EMPTY);
    chk("l5_c5_busy", busy, 0);
    // build tag 3 shared by cores 0 and 2
    send1(LOAD_REQ, 5'd3, 64'd0, 2'd0);
    serve_load(5'd3, 2'd0, 64'h11, ME_E);
    send1(LOAD_REQ, 5'd3, 64'd0, 2'd2);
    wait_type(INV_FWD, "t3b_inv");
    chk("t3b_share", share_list, 4'b0001);
    tick;
    send3(INV_FWDACK, 5'd3, 64'h22, 2'd0);
    wait_type(STORE_MEM, "t3b_st");
    chk("t3b_st_data", msg2_data, 64'h22);
    tick;
    send3(STORE_MEM_ACK, 5'd3, 64'd0, 2'd0);
    chk("t3b_dack", msg2_type, DATA_ACK);
    chk("t3b_owner", cache_owner, 2);
    chk("t3b_mesi", mesi_send, ME_S);
    chk("t3b_data", msg2_data, 64'h22);
    send1(LOAD_REQ, 5'd3, 64'd0, 2'd0);
    wait_type(LOAD_MEM, "t3c_ld");
    tick;
    send3(LOAD_MEM_ACK, 5'd4, 64'h99, 2'd0);
    chk("t3c_wrong_tag", msg2_type, EMPTY);
    chk("t3c_busy", busy, 1);
    send3(LOAD_MEM_ACK, 5'd3, 64'h33, 2'd0);
    chk("t3c_dack", msg2_type, DATA_ACK);
    chk("t3c_mesi", mesi_send, ME_S);
    chk("t3c_owner", cache_owner, 0);
    // store tag 3 from core 1 invalidates sharers 0 and 2
    send1(STORE_REQ, 5'd3, 64'd0, 2'd1);
    wait_type(INV_FWD, "t3d_inv");
    chk("t3d_share", share_list, 4'b0101);
    tick;
    send3(INV_FWDACK, 5'd3, 64'd0, 2'd0);
    send3(INV_FWDACK, 5'd3, 64'd0, 2'd3);
    tick;
    chk("t3d_pending", msg2_type, EMPTY);
    chk("t3d_busy", busy, 1);
    send3(INV_FWDACK, 5'd3, 64'd0, 2'd2);
    serve_load(5'd3, 2'd1, 64'h44, ME_M);
    // tag 7 owned by core 3, then load from core 0
    send1(STORE_REQ, 5'd7, 64'd0, 2'd3);
    serve_load(5'd7, 2'd3, 64'h70, ME_M);
    send1(LOAD_REQ, 5'd7, 64'd0, 2'd0);
    wait_type(INV_FWD, "t7_inv");
    chk("t7_share", share_list, 4'b1000);
    tick;
    send3(INV_FWDACK, 5'd7, 64'hAB, 2'd3);
    wait_type(STORE_MEM, "t7_st");
    chk("t7_st_data", msg2_data, 64'hAB);
    tick;
    send3(STORE_MEM_ACK, 5'd7, 64'd0, 2'd0);
    chk("t7_dack", msg2_type, DATA_ACK);
    chk("t7_data", msg2_data, 64'hAB);
    chk("t7_mesi", mesi_send, ME_S);
    chk("t7_owner", cache_owner, 0);
    // writeback tag 7 returns it to I
    send1(WB_REQ, 5'd7, 64'h55, 2'd0);
    wait_type(STORE_MEM, "wb_st");
    chk("wb_st_data", msg2_data, 64'h55);
    tick;
    send3(STORE_MEM_ACK, 5'd7, 64'd0, 2'd0);
    chk("wb_ack", msg2_type, WB_ACK);
    chk("wb_owner", cache_owner, 0);
    send1(LOAD_REQ, 5'd7, 64'd0, 2'd1);
    serve_load(5'd7, 2'd1, 64'h66, ME_E);
    // fill FIFO while busy, then push while full at the pop edge
    send1(LOAD_REQ, 5'd10, 64'd0, 2'd0);
    wait_type(LOAD_MEM, "f_ld10");
    for (int t = 11; t <= 14; t++) send1(LOAD_REQ, 5'(t), 64'd0, 2'd1);
    chk("f_full_ovf", req_ovf, 0);
    tick;
    send3(LOAD_MEM_ACK, 5'd10, 64'd0, 2'd0);
    chk("f_dack10", msg2_tag, 10);
    tick;
    send1(LOAD_REQ, 5'd15, 64'd0, 2'd1);
    chk("f_pushpop_ovf", req_ovf, 0);
    for (int t = 11; t <= 15; t++) serve_load(5'(t), 2'd1, 64'(t), ME_E);
    tick;
    tick;
    chk("f_idle", busy, 0);
    // six requests while busy: fifth overflows
    send1(LOAD_REQ, 5'd20, 64'd0, 2'd0);
    wait_type(LOAD_MEM, "o_ld20");
    for (int i = 0; i < 6; i++) begin
      send1(LOAD_REQ, 5'(21 + i), 64'd0, 2'd2);
      if (i == 3) chk("o_ovf_4th", req_ovf, 0);
      if (i == 4) chk("o_ovf_5th", req_ovf, 1);
    end
    send3(LOAD_MEM_ACK, 5'd20, 64'd0, 2'd0);
    chk("o_dack20", msg2_tag, 20);
    for (int t = 21; t <= 24; t++) serve_load(5'(t), 2'd2, 64'(t), ME_E);
    for (int i = 0; i < 5; i++) tick;
    chk("o_drained", busy, 0);
    chk("o_sticky", req_ovf, 1);
    // reset during INV abandons the transaction and clears the directory
    send1(LOAD_REQ, 5'd5, 64'd0, 2'd1);
    wait_type(INV_FWD, "r_inv");
    chk("r_share", share_list, 4'b0100);
    tick;
    chk("r_busy_pre", busy, 1);
    rst = 1'b1;
    #1;
    chk("r_busy", busy, 0);
    chk("r_type", msg2_type, EMPTY);
    chk("r_ovf", req_ovf, 0);
    tick;
    rst = 1'b0;
    tick;
    send1(LOAD_REQ, 5'd5, 64'd0, 2'd1);
    serve_load(5'd5, 2'd1, 64'h5, ME_E);
    tick;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
